// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU front end.
//   NOP_INST          bubble encoding (addi x0,x0,0)
//   RESET_PC_DEFAULT  default fetch PC after reset
//   fetch_state_e     instruction-fetch FSM states
//   word_align()      clears the byte-offset bits of an address
package cpu_pkg;

    localparam logic [31:0] NOP_INST         = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HAVE = 2'd2
    } fetch_state_e;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register.
//   clk, rst   clock and synchronous active-high reset
//   stall      hold the register contents
//   flush      load a bubble (valid=0, inst=NOP); wins over stall, pc kept
//   if_valid   fetch stage has a valid instruction this cycle
//   if_pc      fetch stage pc
//   if_inst    fetch stage instruction
//   id_pc      registered pc
//   id_inst    registered instruction
//   id_valid   registered valid
module if_id_reg
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INST = cpu_pkg::NOP_INST
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        if_valid,
    input  logic [31:0] if_pc,
    input  logic [31:0] if_inst,
    output logic [31:0] id_pc,
    output logic [31:0] id_inst,
    output logic        id_valid
);

    logic [31:0] id_pc_reg;
    logic [31:0] id_inst_reg;
    logic        id_valid_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            id_pc_reg    <= RESET_PC;
            id_inst_reg  <= NOP_INST;
            id_valid_reg <= 1'b0;
        end else if (flush) begin
            // pc is deliberately left alone so the bubble still carries
            // the address of the squashed slot
            id_inst_reg  <= NOP_INST;
            id_valid_reg <= 1'b0;
        end else if (!stall) begin
            if (if_valid) begin
                id_pc_reg    <= if_pc;
                id_inst_reg  <= if_inst;
                id_valid_reg <= 1'b1;
            end else begin
                id_inst_reg  <= NOP_INST;
                id_valid_reg <= 1'b0;
            end
        end
    end

    assign id_pc    = id_pc_reg;
    assign id_inst  = id_inst_reg;
    assign id_valid = id_valid_reg;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage.
// Holds the fetch PC, runs a single-outstanding req/gnt/rvalid fetch on
// instruction memory, presents pc/inst to the hazard logic, takes the next
// PC back on npc_i and feeds the IF/ID register.
//   clk, rst                 clock and synchronous active-high reset
//   npc_i                    next PC from hazard logic (used only in HAVE)
//   id_stall_i, id_flush_i   downstream backpressure / bubble insertion
//   if_pc_o, if_inst_o, if_valid_o            current fetch slot
//   imem_req_o, imem_addr_o, imem_gnt_i,
//   imem_rvalid_i, imem_rdata_i               instruction memory port
//   id_pc_o, id_inst_o, id_valid_o            IF/ID register
module if_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INST = cpu_pkg::NOP_INST
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] npc_i,
    input  logic        id_stall_i,
    input  logic        id_flush_i,
    output logic [31:0] if_pc_o,
    output logic [31:0] if_inst_o,
    output logic        if_valid_o,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] id_pc_o,
    output logic [31:0] id_inst_o,
    output logic        id_valid_o
);

    fetch_state_e state_reg;
    logic [31:0]  pc_reg;
    logic [31:0]  inst_reg;
    logic         if_valid_reg;
    logic [31:0]  npc_aligned;

    assign npc_aligned = word_align(npc_i);

    // Only one transaction is ever outstanding: gnt is honoured only in REQ
    // and rvalid only in WAIT, so a response still in flight across a reset
    // lands in REQ and is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= REQ;
            pc_reg       <= RESET_PC;
            inst_reg     <= NOP_INST;
            if_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                REQ: begin
                    if (imem_gnt_i) begin
                        state_reg <= WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rvalid_i) begin
                        inst_reg     <= imem_rdata_i;
                        if_valid_reg <= 1'b1;
                        state_reg    <= HAVE;
                    end
                end
                HAVE: begin
                    // npc equal to the current pc is a hazard bubble: keep
                    // presenting the same instruction without refetching
                    if (!id_stall_i && (npc_aligned != pc_reg)) begin
                        pc_reg       <= npc_aligned;
                        if_valid_reg <= 1'b0;
                        state_reg    <= REQ;
                    end
                end
                default: begin
                    state_reg <= REQ;
                end
            endcase
        end
    end

    // Request is suppressed while reset is asserted so memory never sees a
    // request from the pre-reset state.
    assign imem_req_o  = (state_reg == REQ) && !rst;
    assign imem_addr_o = word_align(pc_reg);
    assign if_pc_o     = pc_reg;
    assign if_valid_o  = if_valid_reg;
    assign if_inst_o   = if_valid_reg ? inst_reg : NOP_INST;

    if_id_reg #(
        .RESET_PC (RESET_PC),
        .NOP_INST (NOP_INST)
    ) u_if_id_reg (
        .clk      (clk),
        .rst      (rst),
        .stall    (id_stall_i),
        .flush    (id_flush_i),
        .if_valid (if_valid_reg),
        .if_pc    (pc_reg),
        .if_inst  (inst_reg),
        .id_pc    (id_pc_o),
        .id_inst  (id_inst_o),
        .id_valid (id_valid_o)
    );

endmodule
